ut_echo_emulator: RTL
=====================

Name: ut_echo_emulator

Overview:
Synthetic transducer/receiver front-end for bench and bring-up. It sits at the far end of the pulse-trigger/AD interface: it consumes the emitted transmit pulse and generates the 8-bit AD sample stream the acquisition path expects. Each trigger produces:
- an initial "main bang" burst,
- followed by a programmable train of decaying echo bursts,
- all superimposed on a fixed baseline.

It replaces the ad-hoc ramp test source for the waveform capture path.

Parameters:
BASELINE, 8'd128, output code when no burst is active
BANG_AMP, 8'd120, amplitude of the initial main-bang burst
MAX_ECHO, 7, upper clamp applied to i_echo_cnt

Ports:
i_clk50M  in  1  system clock
i_rst_n  in  1  reset
i_trig  in  1  transmit pulse, asynchronous, rising edge starts a frame
i_en  in  1  frame-start enable, sampled at trigger edge
i_echo_delay  in  16  cycles from end of main bang to first echo
i_echo_gap  in  16  cycles between end of one echo and start of next
i_echo_cnt  in  3  number of echoes, 0..7
i_amp0  in  8  amplitude of first echo
i_atten_shift  in  2  per-echo attenuation: amp_next = amp >> shift (0 = no decay)
i_burst_len  in  8  samples per burst; 0 treated as 1
o_ad_data  out  8  emulated AD sample, registered
o_busy  out  1  high from FIRE entry through DONE
o_echo_idx  out  3  index of current/last echo, 0-based
o_frame_done  out  1  one-cycle pulse at frame end

Reset is asynchronous, active-low, on i_rst_n; the block is clocked by i_clk50M.

Behaviour:
- Reset values: o_ad_data=BASELINE, o_busy=0, o_echo_idx=0, o_frame_done=0, FSM=IDLE, all counters 0.
- Trigger input:
  - i_trig passes through a 2-flop synchronizer plus a third flop; edge = sync2 & !sync3.
  - A frame starts on edge only when FSM=IDLE and i_en=1.
  - Edges in any other state are ignored; they are not queued.
- Frame start latches all config inputs (delay, gap, cnt clamped to MAX_ECHO, amp0, shift, burst_len). Input changes mid-frame have no effect.
- Latency: the first FIRE sample appears on o_ad_data exactly 4 clocks after the first clock edge that samples i_trig high.
- FSM states: IDLE, FIRE, DELAY, ECHO, GAP, DONE.
  - IDLE -> FIRE on accepted edge.
  - FIRE: emits burst_len samples at BANG_AMP. Then goes to DELAY, or straight to DONE if cnt=0.
  - DELAY: counts i_echo_delay cycles, then -> ECHO. Delay 0 means ECHO in the cycle after FIRE ends.
  - ECHO: emits burst_len samples at the current amp. Then:
    - o_echo_idx < cnt-1: increment idx, amp <= amp >> shift, -> GAP.
    - otherwise -> DONE.
  - GAP: counts i_echo_gap cycles (0 = back-to-back), then -> ECHO.
  - DONE: o_frame_done=1 for one cycle, o_busy falls, -> IDLE.
- Burst samples alternate in polarity, starting positive at sample 0:
  - Even samples: BASELINE+amp, saturated at 255 (9-bit add).
  - Odd samples: BASELINE-amp, saturated at 0 (9-bit signed subtract).
- Outside FIRE/ECHO, o_ad_data = BASELINE.
- Amplitude decay: amp is 8-bit and decays to 0. A 0-amp echo still occupies its slot and outputs BASELINE.
- o_echo_idx resets to 0 at frame start and holds its last value after DONE.
- Asynchronous reset mid-frame forces the reset values immediately. A trigger still high after reset release does not start a frame until a new rising edge.

Optional Feature:
NOISE_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every clock.
  - Its 2 LSBs, mapped to {-1,0,0,+1}, are added to every o_ad_data sample, after the burst value and then saturated to 0..255.
- Undefined: no LFSR logic; output is deterministic as above.
- Test plan values assume NOISE_EN undefined.

Test Plan:
1. Reset then idle: hold i_trig=0 for 100 cycles -> o_ad_data=128 constant, o_busy=0, o_frame_done never pulses.
2. Single-echo frame (burst_len=4, cnt=1, delay=10, amp0=50, i_en=1; raise i_trig):
   - 4 clocks later o_ad_data = 248,8,248,8;
   - then 10×128, then 178,78,178,78;
   - then one o_frame_done pulse; o_busy spans exactly 19 cycles.
3. Decay and gap (cnt=3, amp0=64, shift=1, gap=2, burst_len=2):
   - echo peaks 192, 160, 144;
   - 2 baseline samples between echoes;
   - o_echo_idx steps 0,1,2.
4. Saturation: BASELINE=128, amp0=200, burst_len=2 -> echo samples 255, 0.
5. Retrigger and disable:
   - Pulse i_trig during DELAY -> frame timing unchanged, no second frame.
   - Trigger with i_en=0 -> no frame; o_busy stays 0.
6. Edge cases:
   - cnt=0 -> DONE directly after the main bang.
   - burst_len=0 -> bursts of exactly 1 sample.
   - Assert i_rst_n low mid-ECHO -> o_ad_data=128 and o_busy=0 with no clock edge.

Source files
------------

// File: rtl/ut_echo_emulator.sv
// Synthetic transducer front-end: turns a transmit trigger into a main bang plus a decaying echo train on an 8-bit AD stream.
// Optional build macro NOISE_EN adds +/-1 LSB LFSR dither to every output sample.
module ut_echo_emulator #(
  parameter logic [7:0] BASELINE = 8'd128,
  parameter logic [7:0] BANG_AMP = 8'd120,
  parameter int         MAX_ECHO = 7
) (
  input  logic        i_clk50M,
  input  logic        i_rst_n,
  input  logic        i_trig,
  input  logic        i_en,
  input  logic [15:0] i_echo_delay,
  input  logic [15:0] i_echo_gap,
  input  logic [2:0]  i_echo_cnt,
  input  logic [7:0]  i_amp0,
  input  logic [1:0]  i_atten_shift,
  input  logic [7:0]  i_burst_len,
  output logic [7:0]  o_ad_data,
  output logic        o_busy,
  output logic [2:0]  o_echo_idx,
  output logic        o_frame_done
);

  localparam logic [2:0] MAX_ECHO_C = MAX_ECHO[2:0];

  typedef enum logic [2:0] {IDLE, FIRE, DELAY, ECHO, GAP, DONE} state_t;

  state_t       state;
  logic         trig_p0, trig_p1, trig_p2, trig_rise_p3;
  logic [7:0]   smp_cnt;
  logic [15:0]  tmr;
  logic [15:0]  cfg_delay, cfg_gap;
  logic [2:0]   cfg_cnt;
  logic [1:0]   cfg_shift;
  logic [7:0]   cfg_blen;
  logic [7:0]   amp;
  logic [2:0]   echo_idx;
  logic         last_smp;
  logic         more_echo;
  logic signed [10:0] level;
  logic signed [10:0] noise;
  logic [7:0]   ad_next;

  function automatic logic [7:0] sat_u8(input logic signed [10:0] v);
    if (v > 11'sd255)
      return 8'd255;
    else if (v < 11'sd0)
      return 8'd0;
    else
      return v[7:0];
  endfunction

  function automatic logic signed [10:0] burst_level(input logic [7:0] a, input logic neg);
    logic signed [10:0] b;
    logic signed [10:0] d;
    b = signed'({3'b000, BASELINE});
    d = signed'({3'b000, a});
    return neg ? (b - d) : (b + d);
  endfunction

`ifdef NOISE_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_clk50M or negedge i_rst_n) begin
    if (!i_rst_n)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    case (lfsr[1:0])
      2'b00:   noise = -11'sd1;
      2'b11:   noise = 11'sd1;
      default: noise = 11'sd0;
    endcase
  end
`else
  assign noise = 11'sd0;
`endif

  // Burst polarity follows sample parity: even samples above baseline, odd below.
  always_comb begin
    level = signed'({3'b000, BASELINE});
    if (state == FIRE)
      level = burst_level(BANG_AMP, smp_cnt[0]);
    else if (state == ECHO)
      level = burst_level(amp, smp_cnt[0]);
    ad_next = sat_u8(level + noise);
  end

  assign last_smp  = (smp_cnt == cfg_blen - 8'd1);
  assign more_echo = (({1'b0, echo_idx} + 4'd1) < {1'b0, cfg_cnt});

  // Synchronizer flops reset high so a trigger held through reset is not seen as a new edge.
  always_ff @(posedge i_clk50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trig_p0      <= 1'b1;
      trig_p1      <= 1'b1;
      trig_p2      <= 1'b1;
      trig_rise_p3 <= 1'b0;
      state        <= IDLE;
      smp_cnt      <= '0;
      tmr          <= '0;
      cfg_delay    <= '0;
      cfg_gap      <= '0;
      cfg_cnt      <= '0;
      cfg_shift    <= '0;
      cfg_blen     <= 8'd1;
      amp          <= '0;
      echo_idx     <= '0;
      o_ad_data    <= BASELINE;
      o_busy       <= 1'b0;
      o_echo_idx   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      trig_p0      <= i_trig;
      trig_p1      <= trig_p0;
      trig_p2      <= trig_p1;
      trig_rise_p3 <= trig_p1 & ~trig_p2;

      // Output stage: registered view of the current state.
      o_ad_data    <= ad_next;
      o_busy       <= (state != IDLE);
      o_frame_done <= (state == DONE);
      o_echo_idx   <= echo_idx;

      case (state)
        IDLE: begin
          if (trig_rise_p3 && i_en) begin
            cfg_delay <= i_echo_delay;
            cfg_gap   <= i_echo_gap;
            cfg_cnt   <= (i_echo_cnt > MAX_ECHO_C) ? MAX_ECHO_C : i_echo_cnt;
            cfg_shift <= i_atten_shift;
            cfg_blen  <= (i_burst_len == 8'd0) ? 8'd1 : i_burst_len;
            amp       <= i_amp0;
            echo_idx  <= '0;
            smp_cnt   <= '0;
            state     <= FIRE;
          end
        end
        FIRE: begin
          if (last_smp) begin
            smp_cnt <= '0;
            if (cfg_cnt == 3'd0) begin
              state <= DONE;
            end else if (cfg_delay == 16'd0) begin
              state <= ECHO;
            end else begin
              tmr   <= cfg_delay - 16'd1;
              state <= DELAY;
            end
          end else begin
            smp_cnt <= smp_cnt + 8'd1;
          end
        end
        DELAY: begin
          if (tmr == 16'd0)
            state <= ECHO;
          else
            tmr <= tmr - 16'd1;
        end
        ECHO: begin
          if (last_smp) begin
            smp_cnt <= '0;
            if (more_echo) begin
              echo_idx <= echo_idx + 3'd1;
              amp      <= amp >> cfg_shift;
              if (cfg_gap == 16'd0) begin
                state <= ECHO;
              end else begin
                tmr   <= cfg_gap - 16'd1;
                state <= GAP;
              end
            end else begin
              state <= DONE;
            end
          end else begin
            smp_cnt <= smp_cnt + 8'd1;
          end
        end
        GAP: begin
          if (tmr == 16'd0)
            state <= ECHO;
          else
            tmr <= tmr - 16'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
